// File: rtl/alu_pkg.sv
// alu_pkg: shared mux geometry and FSM state type for the ALU result mux control stage
package alu_pkg;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 4;
    localparam int NUM_IN = 2**SEL_W;
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
endpackage

// File: rtl/alu_mux_ctrl_if.sv
// alu_mux_ctrl_if: command, mux and result signals of alu_mux_ctrl
//   cmd_*  : command handshake (valid/ready, start select, sweep flag)
//   selMUX : select driven to the mux, M : mux output sampled back
//   res_*  : result handshake (valid/ready, packed slots, captured-slot mask)
//   busy   : controller not idle
//   slave  : controller view, master : environment view
interface alu_mux_ctrl_if;
    import alu_pkg::*;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [SEL_W-1:0]         cmd_sel;
    logic                     cmd_sweep;
    logic [SEL_W-1:0]         selMUX;
    logic [DATA_W-1:0]        M;
    logic                     res_valid;
    logic                     res_ready;
    logic [NUM_IN*DATA_W-1:0] res_data;
    logic [NUM_IN-1:0]        res_mask;
    logic                     busy;
    modport slave (
        input  cmd_valid, cmd_sel, cmd_sweep, M, res_ready,
        output cmd_ready, selMUX, res_valid, res_data, res_mask, busy
    );
    modport master (
        output cmd_valid, cmd_sel, cmd_sweep, M, res_ready,
        input  cmd_ready, selMUX, res_valid, res_data, res_mask, busy
    );
endinterface

// File: rtl/alu_mux_ctrl.sv
// alu_mux_ctrl: drives the ALU result mux select and captures its output per command
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_mux_ctrl_if.slave (command in, select out, M in, result out, busy)
//   SETTLE_CYCLES : cycles selMUX is held before M is sampled (>= 1)
module alu_mux_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mux_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] STEP_LAST = SEL_W'(NUM_IN - 1);
    state_t                   r_state;
    logic [SEL_W-1:0]         r_sel;
    logic                     r_sweep;
    logic [CNT_W-1:0]         r_settle;
    logic [SEL_W-1:0]         r_step;
    logic [NUM_IN*DATA_W-1:0] r_data;
    logic [NUM_IN-1:0]        r_mask;
    logic                     r_valid;
    logic                     w_sample;
    logic                     w_last;
    assign w_sample = (r_settle == SETTLE_LAST);
    assign w_last   = !r_sweep || (r_step == STEP_LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_sweep  <= 1'b0;
            r_settle <= '0;
            r_step   <= '0;
            r_data   <= '0;
            r_mask   <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.cmd_valid) begin
                    r_sel    <= bus.cmd_sel;
                    r_sweep  <= bus.cmd_sweep;
                    r_data   <= '0;
                    r_mask   <= '0;
                    r_settle <= '0;
                    r_step   <= '0;
                    r_state  <= SETTLE;
                end
                SETTLE: begin
                    r_settle <= r_settle + CNT_W'(1);
                    if (w_sample) begin
                        // slot placement follows the select value, not the sweep step
                        r_data[r_sel*DATA_W +: DATA_W] <= bus.M;
                        r_mask[r_sel] <= 1'b1;
                        if (w_last) begin
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_sel    <= r_sel + SEL_W'(1);
                            r_step   <= r_step + SEL_W'(1);
                            r_settle <= '0;
                        end
                    end
                end
                DONE: if (bus.res_ready) begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.selMUX    = r_sel;
    assign bus.res_valid = r_valid;
    assign bus.res_data  = r_data;
    assign bus.res_mask  = r_mask;
endmodule

// File: doc/alu_mux_ctrl.md
Name: alu_mux_ctrl

Overview:
- Control stage that drives the 2-bit select of the ALU result multiplexer and captures the 4-bit mux output `M`.
- Accepts commands over a valid/ready handshake. In single mode it samples one mux input; in sweep mode it samples all four in turn.
- Returns the captured results as a packed word over a second valid/ready handshake.
- Sits directly upstream of the multiplexer on select and directly downstream of it on data.

Parameters:
- SEL_W, 2, mux select width; the number of mux inputs is 2**SEL_W.
- DATA_W, 4, width of mux output `M` and of each result slot.
- SETTLE_CYCLES, 1, clock cycles `selMUX` is held stable before `M` is sampled; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_sel  input  SEL_W  start select value; in single mode, the only select.
- cmd_sweep  input  1  1 = sample all 2**SEL_W inputs; 0 = sample only cmd_sel.
- selMUX  output  SEL_W  select to the multiplexer, registered.
- M  input  DATA_W  multiplexer output.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  (2**SEL_W)*DATA_W  slot k = bits [k*DATA_W +: DATA_W] holds M sampled with selMUX=k.
- res_mask  output  2**SEL_W  bit k set = slot k was captured by the current command.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous, active-low, one clock: clk, rst_n.
- Reset values: state=IDLE, selMUX=0, res_valid=0, res_data=0, res_mask=0, busy=0, settle counter=0, step counter=0. cmd_ready=1 once reset is released.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: load selMUX=cmd_sel, latch cmd_sweep, clear res_data and res_mask, clear both counters, go to SETTLE.
  - selMUX keeps its last value while idle.
- SETTLE:
  - The settle counter increments each cycle.
  - On the edge that completes the SETTLE_CYCLES-th cycle with the current selMUX:
    - write M into slot selMUX and set res_mask[selMUX];
    - in single mode, go to DONE;
    - in sweep mode, if the step counter equals 2**SEL_W-1, go to DONE;
    - otherwise, on the same edge: selMUX=selMUX+1 (mod 2**SEL_W, wraps 3->0), step counter+1, settle counter=0.
- DONE:
  - res_valid=1; res_data and res_mask are stable.
  - On res_ready: res_valid=0, go to IDLE.
  - cmd_ready=1 again on the following cycle; a command is never accepted on the same edge as the result handshake.
- Latency, command acceptance edge to the edge where res_valid rises:
  - single mode: SETTLE_CYCLES cycles;
  - sweep mode: 4*SETTLE_CYCLES cycles.
- Sweep order starts at cmd_sel and wraps, e.g. cmd_sel=2 gives order 2,3,0,1. Slot placement always follows the select value, not the step order.
- cmd_ready=0 in SETTLE and DONE. A cmd_valid seen in those states is ignored and not queued.
- res_ready while res_valid=0 has no effect.
- cmd_sel and cmd_sweep are sampled only on the acceptance edge; later changes do not affect the command in flight.
- Reset asserted mid-command:
  - all outputs return to their reset values immediately (asynchronously);
  - the command in flight is discarded;
  - no partial result is presented.
- Arithmetic: select increment is modulo 2**SEL_W. Step counter width is SEL_W. Settle counter width is $clog2(SETTLE_CYCLES+1).

Decomposition:
- Shared package alu_pkg holds:
  - FSM state typedef (IDLE/SETTLE/DONE);
  - SEL_W and DATA_W constants, shared with the Multiplexer;
  - a NUM_IN=2**SEL_W constant.
- No sub-module. The settle counter and the result capture register bank stay inline.

Test Plan:
- Reset: hold rst_n=0 -> selMUX=0, res_valid=0, res_data=0, res_mask=0, busy=0. Release -> cmd_ready=1.
- Single mode:
  - Stimulus: SETTLE_CYCLES=1, mux model M=4'hA when sel=1; cmd_sel=1, cmd_sweep=0, res_ready=1.
  - Response: selMUX=1 one edge after acceptance; res_valid the next edge; res_data=16'h00A0; res_mask=4'b0010.
- Sweep with wrap:
  - Stimulus: M=sel+4'h5; cmd_sel=2, cmd_sweep=1.
  - Response: selMUX sequence 2,3,0,1; res_data=16'h8765; res_mask=4'b1111; res_valid 4 cycles after acceptance.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles after res_valid; pulse cmd_valid during that time.
  - Response: res_valid stays high, res_data is stable, cmd_ready=0, the new command is not accepted.
  - Release: res_ready=1 -> IDLE, then cmd_ready=1 on the next cycle.
- Settle timing:
  - Stimulus: SETTLE_CYCLES=3; mux model returns X for 2 cycles after sel changes, then valid data.
  - Response: no X captured; single-mode latency = 3 cycles.
- Reset mid-sweep: assert rst_n=0 after the second sample -> immediate reset values; no res_valid after release.
